// File: rtl/tuser_pkg.sv
// Shared constants, FSM state encoding and the byte-to-beat helper for the
// ingress tuser capture block.
package tuser_pkg;

  localparam int TUSER_W    = 128;
  localparam int DATA_BYTES = 32;
  localparam int BEAT_W     = 12;
  localparam int CNT_W      = 32;
  localparam int LEN_LSB    = 0;
  localparam int LEN_MSB    = 15;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    IN_PKT   = 1'b1
  } state_t;

  localparam logic [LEN_W:0] LEN_ONE = 1;

  // One extra bit of headroom so a 0xFFFF length cannot wrap before the shift.
  function automatic logic [LEN_W:0] bytes_to_beats(input logic [LEN_W-1:0] len,
                                                    input int unsigned  log2_bytes);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_ONE << log2_bytes) - LEN_ONE;
    return sum >> log2_bytes;
  endfunction

endpackage

// File: rtl/tuser_len_chk.sv
// Per-packet beat counter and length check against the tuser length field;
// produces the packet counter, error pulse and error counter.
module tuser_len_chk #(
  parameter int DATA_BYTES = tuser_pkg::DATA_BYTES,
  parameter int BEAT_W     = tuser_pkg::BEAT_W,
  parameter int CNT_W      = tuser_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sop,
  input  logic                        mid,
  input  logic                        eop,
  input  logic [tuser_pkg::LEN_W-1:0] len,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic                        len_err,
  output logic [CNT_W-1:0]            err_cnt
);
  import tuser_pkg::*;

  localparam int unsigned       LOG2_BYTES = $clog2(DATA_BYTES);
  localparam logic [BEAT_W-1:0] BEAT_MAX   = '1;
  localparam logic [BEAT_W:0]   ONE_BEAT   = 1;

  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] next_cnt;
  logic [BEAT_W:0]   exp_beats;
  logic [BEAT_W:0]   new_exp;

  assign new_exp  = (BEAT_W+1)'(bytes_to_beats(len, LOG2_BYTES));
  assign next_cnt = (beat_cnt == BEAT_MAX) ? BEAT_MAX : beat_cnt + 1'b1;

  // A single-beat packet is checked against the length it carries on that same
  // beat, since exp_beats has not been loaded yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      exp_beats <= '0;
      pkt_cnt   <= '0;
      len_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      len_err <= 1'b0;
      if (sop) begin
        exp_beats <= new_exp;
        beat_cnt  <= BEAT_W'(1);
        if (eop) begin
          pkt_cnt <= pkt_cnt + 1'b1;
          if (new_exp != ONE_BEAT) begin
            len_err <= 1'b1;
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end else if (mid) begin
        beat_cnt <= next_cnt;
        if (eop) begin
          pkt_cnt <= pkt_cnt + 1'b1;
          if ({1'b0, next_cnt} != exp_beats) begin
            len_err <= 1'b1;
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tuser_in_fsm.sv
// Ingress AXIS framing FSM: captures tuser on each SOP beat and presents it
// once as the SDNet input tuple; length checking lives in tuser_len_chk.
module tuser_in_fsm #(
  parameter int TUSER_W    = tuser_pkg::TUSER_W,
  parameter int DATA_BYTES = tuser_pkg::DATA_BYTES,
  parameter int BEAT_W     = tuser_pkg::BEAT_W,
  parameter int CNT_W      = tuser_pkg::CNT_W
) (
  input  logic               tin_aclk,
  input  logic               tin_arst,
  input  logic               tin_avalid,
  input  logic               tin_aready,
  input  logic               tin_tlast,
  input  logic [TUSER_W-1:0] tin_atuser,
  output logic               tin_valid,
  output logic [TUSER_W-1:0] tin_data,
  output logic [CNT_W-1:0]   tin_pkt_cnt,
  output logic               tin_len_err,
  output logic [CNT_W-1:0]   tin_err_cnt
);
  import tuser_pkg::*;

  state_t state;
  logic   beat;
  logic   sop;
  logic   mid;
  logic   eop;

  assign beat = tin_avalid & tin_aready;
  assign sop  = beat & (state == WAIT_SOP);
  assign mid  = beat & (state == IN_PKT);
  assign eop  = beat & tin_tlast;

  // tin_data is only ever loaded on an SOP beat, so it holds between packets.
  always_ff @(posedge tin_aclk or negedge tin_arst) begin
    if (!tin_arst) begin
      state     <= WAIT_SOP;
      tin_valid <= 1'b0;
      tin_data  <= '0;
    end else begin
      tin_valid <= 1'b0;
      case (state)
        WAIT_SOP: begin
          if (beat) begin
            tin_data  <= tin_atuser;
            tin_valid <= 1'b1;
            if (!tin_tlast) state <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (beat && tin_tlast) state <= WAIT_SOP;
        end
        default: state <= WAIT_SOP;
      endcase
    end
  end

  tuser_len_chk #(
    .DATA_BYTES(DATA_BYTES),
    .BEAT_W    (BEAT_W),
    .CNT_W     (CNT_W)
  ) u_len_chk (
    .clk    (tin_aclk),
    .rst_n  (tin_arst),
    .sop    (sop),
    .mid    (mid),
    .eop    (eop),
    .len    (tin_atuser[LEN_MSB:LEN_LSB]),
    .pkt_cnt(tin_pkt_cnt),
    .len_err(tin_len_err),
    .err_cnt(tin_err_cnt)
  );

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Randomised bench for tuser_in_fsm; expectations come from a packet-level
// model (one tuple per packet, error when the beat count misses ceil(len/32)).
module tb_tuser_in_fsm;

  localparam int TUSER_W    = 128;
  localparam int DATA_BYTES = 32;
  localparam int BEAT_W     = 12;
  localparam int CNT_W      = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               avalid;
  logic               aready;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;
  logic               tin_valid;
  logic [TUSER_W-1:0] tin_data;
  logic [CNT_W-1:0]   tin_pkt_cnt;
  logic               tin_len_err;
  logic [CNT_W-1:0]   tin_err_cnt;

  int checks = 0;
  int errors = 0;

  bit                 exp_valid;
  bit                 exp_err;
  logic [TUSER_W-1:0] model_data;
  int unsigned        model_pkt;
  int unsigned        model_err;

  tuser_in_fsm #(
    .TUSER_W   (TUSER_W),
    .DATA_BYTES(DATA_BYTES),
    .BEAT_W    (BEAT_W),
    .CNT_W     (CNT_W)
  ) dut (
    .tin_aclk   (clk),
    .tin_arst   (rst_n),
    .tin_avalid (avalid),
    .tin_aready (aready),
    .tin_tlast  (tlast),
    .tin_atuser (tuser),
    .tin_valid  (tin_valid),
    .tin_data   (tin_data),
    .tin_pkt_cnt(tin_pkt_cnt),
    .tin_len_err(tin_len_err),
    .tin_err_cnt(tin_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit len_mismatch(input int unsigned len, input int unsigned nbeats);
    int unsigned want    = (len + DATA_BYTES - 1) / DATA_BYTES;
    int unsigned sat_max = (1 << BEAT_W) - 1;
    int unsigned counted = (nbeats > sat_max) ? sat_max : nbeats;
    return counted != want;
  endfunction

  task automatic checkOutput(input string tag, input logic [TUSER_W-1:0] got,
                             input logic [TUSER_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("tin_valid",   TUSER_W'(tin_valid),   TUSER_W'(exp_valid));
    checkOutput("tin_len_err", TUSER_W'(tin_len_err), TUSER_W'(exp_err));
    checkOutput("tin_pkt_cnt", TUSER_W'(tin_pkt_cnt), TUSER_W'(model_pkt));
    checkOutput("tin_err_cnt", TUSER_W'(tin_err_cnt), TUSER_W'(model_err));
    checkOutput("tin_data",    tin_data,              model_data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkAll();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic model_reset();
    model_data = '0;
    model_pkt  = 0;
    model_err  = 0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      avalid = 1'(($urandom_range(1)));
      aready = 1'b0;
      tlast  = 1'(($urandom_range(1)));
      tuser  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
  endtask

  // Sends one packet of nbeats beats; valid/ready are randomised per cycle.
  task automatic applyStimulus(input int unsigned len, input int unsigned nbeats,
                               input logic [TUSER_W-1:0] tu_base,
                               input int unsigned valid_pct, input int unsigned ready_pct);
    logic [TUSER_W-1:0] tu;
    int unsigned        b;
    bit                 is_beat;
    tu       = tu_base;
    tu[15:0] = 16'(len);
    b        = 0;
    while (b < nbeats) begin
      avalid  = ($urandom_range(99) < valid_pct);
      aready  = ($urandom_range(99) < ready_pct);
      tlast   = avalid ? (b == nbeats - 1) : 1'(($urandom_range(1)));
      tuser   = (b == 0) ? tu : {$urandom, $urandom, $urandom, $urandom};
      is_beat = avalid && aready;
      if (is_beat) begin
        if (b == 0) begin
          exp_valid  = 1'b1;
          model_data = tu;
        end
        if (b == nbeats - 1) begin
          model_pkt++;
          if (len_mismatch(len, nbeats)) begin
            model_err++;
            exp_err = 1'b1;
          end
        end
        b++;
      end
      step();
    end
    avalid = 1'b0;
    tlast  = 1'b0;
  endtask

  function automatic logic [TUSER_W-1:0] rnd_tuser();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [TUSER_W-1:0] tu;
    int unsigned        len;
    int                 nb;

    rst_n  = 1'b0;
    avalid = 1'b0;
    aready = 1'b0;
    tlast  = 1'b0;
    tuser  = '0;
    model_reset();

    #2;
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    tu = {$urandom, $urandom, $urandom, 32'hABCD_0000};
    applyStimulus(64, 2, tu, 100, 100);
    idle(2);
    applyStimulus(20, 1, rnd_tuser(), 100, 100);
    idle(1);
    applyStimulus(100, 3, rnd_tuser(), 100, 100);
    idle(1);
    applyStimulus(96, 3, rnd_tuser(), 100, 50);
    idle(1);

    applyStimulus(32, 1, rnd_tuser(), 100, 100);
    applyStimulus(64, 2, rnd_tuser(), 100, 100);
    applyStimulus(32, 1, rnd_tuser(), 100, 100);
    idle(2);

    applyStimulus(0, 1, rnd_tuser(), 100, 100);
    applyStimulus(32, 1, rnd_tuser(), 100, 100);
    applyStimulus(33, 2, rnd_tuser(), 100, 100);
    applyStimulus(33, 1, rnd_tuser(), 100, 100);
    applyStimulus(65535, 2048, rnd_tuser(), 100, 100);
    applyStimulus(65535, 4200, rnd_tuser(), 100, 100);
    idle(2);

    // Abort a 4-beat packet after its second beat with an asynchronous reset.
    tu       = rnd_tuser();
    tu[15:0] = 16'd128;
    avalid   = 1'b1;
    aready   = 1'b1;
    tlast    = 1'b0;
    tuser    = tu;
    exp_valid  = 1'b1;
    model_data = tu;
    step();
    tuser = rnd_tuser();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    checkAll();
    step();
    step();
    rst_n  = 1'b1;
    avalid = 1'b0;
    idle(1);
    applyStimulus(8, 1, rnd_tuser(), 100, 100);
    idle(2);

    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(400);
      nb  = int'((len + DATA_BYTES - 1) / DATA_BYTES) + int'($urandom_range(2)) - 1;
      if (nb < 1) nb = 1;
      applyStimulus(len, nb, rnd_tuser(), $urandom_range(50, 100), $urandom_range(50, 100));
      if ($urandom_range(1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tuser_in_fsm.md
Name: tuser_in_fsm

Overview:
- Upstream neighbour of the tuser output stage, sitting on the ingress AXI-Stream into the SDNet packet engine.
- On the first accepted beat of every packet (SOP), it latches the 128-bit AXIS tuser and presents it once as the SDNet input tuple (valid pulse plus data).
- Tracks packet framing and checks the beat count of each packet against the length field carried in tuser[15:0].
- Provides a packet counter and a length-error pulse for debug.

Parameters:
TUSER_W, 128, width of AXIS tuser and of the tuple data
DATA_BYTES, 32, bytes per AXIS beat (256-bit bus); power of two
BEAT_W, 12, width of the per-packet beat counter (saturating)
CNT_W, 32, width of the packet and error counters (wrapping)

Ports:
tin_aclk  input  1  single clock; all logic is on the rising edge
tin_arst  input  1  asynchronous, active-low reset
tin_avalid  input  1  AXIS tvalid of the ingress stream (observed, not driven)
tin_aready  input  1  AXIS tready of the ingress stream (observed, not driven)
tin_tlast  input  1  AXIS tlast
tin_atuser  input  TUSER_W  AXIS tuser; [15:0] is packet length in bytes
tin_valid  output  1  tuple valid, one-cycle pulse per packet
tin_data  output  TUSER_W  tuple data, held until the next SOP
tin_pkt_cnt  output  CNT_W  number of completed packets
tin_len_err  output  1  one-cycle pulse on length mismatch
tin_err_cnt  output  CNT_W  number of length mismatches

Behaviour:
- Beat definition: beat = tin_avalid & tin_aready. Nothing advances without a beat. tvalid without tready is ignored.
- Reset (tin_arst = 0, asynchronous): state = WAIT_SOP; beat_cnt = 0; exp_beats = 0.
  - All outputs reset to 0: tin_valid, tin_data, tin_pkt_cnt, tin_len_err, tin_err_cnt.
  - Deassertion is synchronised by the instantiating level.
- FSM, state WAIT_SOP:
  - On a beat: tin_data <= tin_atuser; tin_valid <= 1 for exactly one cycle (latency 1 from the SOP beat).
  - exp_beats <= (len + DATA_BYTES-1) >> log2(DATA_BYTES), computed at BEAT_W+1 width with no overflow. len 0 gives exp_beats 0.
  - beat_cnt <= 1.
  - If tin_tlast = 1 (single-beat packet): run the end-of-packet check and stay in WAIT_SOP. Otherwise go to IN_PKT.
- FSM, state IN_PKT:
  - On a beat: beat_cnt += 1, saturating at 2^BEAT_W-1. tuser is ignored (not re-latched).
  - On a beat with tin_tlast = 1: run the end-of-packet check and go to WAIT_SOP.
- End-of-packet check, registered with latency 1 after the tlast beat:
  - tin_pkt_cnt += 1 (wraps).
  - If the final beat count (including the tlast beat) != exp_beats: tin_len_err pulses 1 for one cycle and tin_err_cnt += 1 (wraps).
  - len 0 therefore always flags an error.
  - A saturated beat count always mismatches unless exp_beats equals the saturation value.
- Back-to-back packets: the tlast beat of packet N followed by the SOP beat of packet N+1 on the next cycle is legal. tin_valid pulses on consecutive SOPs with no bubble. tin_len_err/pkt_cnt for N and tin_valid for N+1 may be asserted in the same cycle.
- tin_data changes only on an SOP beat and is stable at least until the next SOP.
- Reset mid-packet: the partial packet is discarded with no pkt_cnt and no error. The first beat after reset release is treated as SOP.
- No backpressure is produced: the tuple consumer must accept one tuple per packet.

Decomposition:
- Package tuser_pkg holds:
  - TUSER_W, DATA_BYTES, LEN_LSB = 0, LEN_MSB = 15;
  - the state encoding (WAIT_SOP, IN_PKT) as a 1-bit enum;
  - a function that derives beats from bytes.
- The length checker (exp_beats register, beat counter, compare, err counter) is a natural sub-module: tuser_len_chk. The FSM and tuple register remain in the top level.

Test Plan:
- Single 64-byte packet, 2 beats, tuser = 0x...ABCD_0040, tready = 1:
  - tin_valid pulses once, 1 cycle after beat 1, with tin_data = the tuser value;
  - tin_pkt_cnt goes to 1;
  - no tin_len_err.
- 1-beat packet, len = 20, tlast on the SOP beat: tuple pulse plus pkt_cnt = 1, both 1 cycle after the beat; no error.
- Length mismatch, len = 100 (exp 4) but tlast on beat 3: tin_len_err pulses 1 cycle after the tlast beat; tin_err_cnt = 1.
- Backpressure, tvalid = 1 with tready toggling 1,0,0,1,1 (3 beats, len = 96):
  - exactly one tin_valid pulse;
  - beats are counted only when tready = 1;
  - no error.
- Three back-to-back packets with no idle cycle, len = 32/64/32: three tin_valid pulses with the correct tin_data each; pkt_cnt = 3; err_cnt = 0.
- Assert reset after beat 2 of a 4-beat packet, release, then send a 1-beat packet (len = 8):
  - all outputs are 0 during reset;
  - the next packet is treated as SOP;
  - pkt_cnt = 1.
